// File: rtl/uart_tx_arb.sv
// Two-port round-robin arbiter in front of a single UART transmitter (wr/busy protocol).
// Optional packet lock is enabled with `define UART_ARB_LOCK_EN.
module uart_tx_arb #(
  parameter int BUSY_TIMEOUT = 3
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  input  logic [1:0]  req_last,
  output logic [1:0]  req_ready,
  output logic        uart_wr,
  output logic [7:0]  uart_dat,
  input  logic        uart_busy,
  output logic [1:0]  grant,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1,
  output logic        fault
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  logic [1:0]    state;
  logic          ptr;
  logic          owner;
  logic [TW-1:0] timer;
  logic [1:0]    win;
  logic          win_idx;

`ifdef UART_ARB_LOCK_EN
  logic lock;
`else
  logic unused_last;
  assign unused_last = ^req_last;
`endif

  always_comb begin
    win = 2'b00;
    if (req_valid[ptr])
      win[ptr] = 1'b1;
    else if (req_valid[!ptr])
      win[!ptr] = 1'b1;
`ifdef UART_ARB_LOCK_EN
    // Mid-packet only the owner may be granted, even while it has nothing to send.
    if (lock) begin
      win = 2'b00;
      win[owner] = req_valid[owner];
    end
`endif
  end

  assign win_idx   = win[1];
  assign req_ready = (resetq && state == IDLE) ? win : 2'b00;
  assign uart_wr   = (state == ISSUE) && !uart_busy;

  always_comb begin
    grant = 2'b00;
    if (resetq) begin
      if (state == IDLE)
        grant = win;
      else
        grant = owner ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      timer    <= '0;
      uart_dat <= 8'h00;
      cnt0     <= 16'h0000;
      cnt1     <= 16'h0000;
      fault    <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|win) begin
            uart_dat <= win_idx ? req_data[15:8] : req_data[7:0];
            owner    <= win_idx;
            state    <= ISSUE;
`ifdef UART_ARB_LOCK_EN
            if (req_last[win_idx]) begin
              lock <= 1'b0;
              ptr  <= !win_idx;
            end else begin
              lock <= 1'b1;
            end
`else
            ptr      <= !win_idx;
`endif
          end
        end
        ISSUE: begin
          if (!uart_busy) begin
            timer <= '0;
            state <= WAIT_BUSY;
            if (owner)
              cnt1 <= cnt1 + 16'd1;
            else
              cnt0 <= cnt0 + 16'd1;
          end
        end
        WAIT_BUSY: begin
          if (uart_busy) begin
            state <= WAIT_DONE;
          end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
            fault <= 1'b1;
            state <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!uart_busy)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: drivers push expected {port,byte}, a monitor checks each uart_wr strobe.
module tb_uart_tx_arb;

  localparam int BT = 3;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
  logic [7:0]  d0 = 8'h00, d1 = 8'h00;
  logic [1:0]  req_ready, grant;
  logic        uart_wr, fault;
  logic [7:0]  uart_dat;
  logic [15:0] cnt0, cnt1;
  logic        uart_busy;
  logic        tie_low = 1'b0;
  logic [3:0]  busy_cnt = 4'd0;

  int checks = 0;
  int failures = 0;
  logic [8:0] sb[$];

  uart_tx_arb #(.BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .resetq(resetq),
    .req_valid({v1, v0}), .req_data({d1, d0}), .req_last({l1, l0}),
    .req_ready(req_ready), .uart_wr(uart_wr), .uart_dat(uart_dat),
    .uart_busy(uart_busy), .grant(grant), .cnt0(cnt0), .cnt1(cnt1), .fault(fault)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for 3 cycles after each strobe unless tied low.
  always @(posedge clk) begin
    if (uart_wr && !tie_low)
      busy_cnt <= 4'd3;
    else if (busy_cnt != 4'd0)
      busy_cnt <= busy_cnt - 4'd1;
  end
  assign uart_busy = (busy_cnt != 4'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expected byte and its owner.
  always @(negedge clk) begin
    if (resetq && uart_wr) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_wr actual=%h required=none", uart_dat);
      end else begin
        chk("sb_byte", {23'd0, grant[1], uart_dat}, {23'd0, sb.pop_front()});
      end
    end
  end

  task automatic send(input int p, input logic [7:0] b, input logic last);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    @(negedge clk);
    if (p == 0) begin v0 = 1'b1; d0 = b; l0 = last; end
    else        begin v1 = 1'b1; d1 = b; l1 = last; end
    while (!done) begin
      #1;
      if (req_ready[p]) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else if (n > 500) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=port%0d_not_ready required=accept", p);
        done = 1'b1;
      end else begin
        n++;
        @(negedge clk);
      end
    end
    if (p == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while ((sb.size() != 0 || uart_busy) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL quiet_timeout actual=pending%0d required=pending0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset: outputs quiet even with both requesters valid.
    v0 = 1'b1; v1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_wr", {31'd0, uart_wr}, 32'd0);
    chk("rst_dat", {24'd0, uart_dat}, 32'd0);
    chk("rst_cnts", {cnt1, cnt0}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    v0 = 1'b0; v1 = 1'b0;
    resetq = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte on port0: strobe the cycle after accept, one cycle wide.
    sb.push_back({1'b0, 8'h55});
    send(0, 8'h55, 1'b1);
    @(negedge clk);
    chk("single_wr", {31'd0, uart_wr}, 32'd1);
    chk("single_dat", {24'd0, uart_dat}, 32'h55);
    chk("single_grant", {30'd0, grant}, 32'd1);
    @(negedge clk);
    chk("single_wr_off", {31'd0, uart_wr}, 32'd0);
    wait_quiet();
    chk("single_cnt0", {16'd0, cnt0}, 32'd1);
    chk("single_idle_grant", {30'd0, grant}, 32'd0);

    // Contention: pointer now favours port1, then strict alternation.
    sb.push_back({1'b1, 8'hB0}); sb.push_back({1'b0, 8'hA0});
    sb.push_back({1'b1, 8'hB1}); sb.push_back({1'b0, 8'hA1});
    sb.push_back({1'b1, 8'hB2}); sb.push_back({1'b0, 8'hA2});
    fork
      begin send(0, 8'hA0, 1'b1); send(0, 8'hA1, 1'b1); send(0, 8'hA2, 1'b1); end
      begin send(1, 8'hB0, 1'b1); send(1, 8'hB1, 1'b1); send(1, 8'hB2, 1'b1); end
    join
    wait_quiet();
    chk("cont_cnt0", {16'd0, cnt0}, 32'd4);
    chk("cont_cnt1", {16'd0, cnt1}, 32'd3);

    // Counter wrap on port1.
    force dut.cnt1 = 16'hFFFE;
    @(negedge clk);
    release dut.cnt1;
    sb.push_back({1'b1, 8'h11});
    send(1, 8'h11, 1'b1);
    wait_quiet();
    chk("wrap_ffff", {16'd0, cnt1}, 32'h0000FFFF);
    sb.push_back({1'b1, 8'h12});
    send(1, 8'h12, 1'b1);
    wait_quiet();
    chk("wrap_zero", {16'd0, cnt1}, 32'h00000000);

    // Busy never rises: fault after the timeout, arbiter returns to IDLE.
    tie_low = 1'b1;
    sb.push_back({1'b0, 8'h3C});
    send(0, 8'h3C, 1'b1);
    @(negedge clk);
    chk("fault_strobe", {31'd0, uart_wr}, 32'd1);
    @(negedge clk);
    chk("fault_early", {31'd0, fault}, 32'd0);
    repeat (BT) @(negedge clk);
    chk("fault_set", {31'd0, fault}, 32'd1);
    chk("fault_idle_grant", {30'd0, grant}, 32'd0);
    sb.push_back({1'b0, 8'h3D});
    send(0, 8'h3D, 1'b1);
    repeat (BT + 4) @(negedge clk);
    chk("fault_next_sent", sb.size(), 32'd0);
    chk("fault_sticky", {31'd0, fault}, 32'd1);
    chk("fault_cnt0", {16'd0, cnt0}, 32'd6);
    tie_low = 1'b0;

    // Reset while the transmitter is busy (WAIT_DONE).
    sb.push_back({1'b1, 8'h77});
    send(1, 8'h77, 1'b1);
    n = 0;
    while (!uart_busy && n < 20) begin n++; @(negedge clk); end
    chk("rst_mid_busy", {31'd0, uart_busy}, 32'd1);
    resetq = 1'b0;
    #1;
    chk("rst_mid_grant", {30'd0, grant}, 32'd0);
    chk("rst_mid_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_mid_wr", {31'd0, uart_wr}, 32'd0);
    chk("rst_mid_dat", {24'd0, uart_dat}, 32'd0);
    chk("rst_mid_cnts", {cnt1, cnt0}, 32'd0);
    chk("rst_mid_fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    resetq = 1'b1;
    wait_quiet();
    chk("rst_after_cnts", {cnt1, cnt0}, 32'd0);

    // Pointer restarts at port0 after reset.
    sb.push_back({1'b0, 8'h01}); sb.push_back({1'b1, 8'h02});
    fork
      send(0, 8'h01, 1'b1);
      send(1, 8'h02, 1'b1);
    join
    wait_quiet();
    chk("post_rst_cnts", {cnt1, cnt0}, {16'd1, 16'd1});

`ifdef UART_ARB_LOCK_EN
    // Packet lock: port1's 3-byte packet is not interleaved with port0.
    sb.push_back({1'b0, 8'hC0}); sb.push_back({1'b1, 8'hD0});
    sb.push_back({1'b1, 8'hD1}); sb.push_back({1'b1, 8'hD2});
    sb.push_back({1'b0, 8'hC1});
    fork
      begin send(0, 8'hC0, 1'b1); send(0, 8'hC1, 1'b1); end
      begin
        send(1, 8'hD0, 1'b0);
        repeat (3) @(negedge clk);
        send(1, 8'hD1, 1'b0);
        repeat (3) @(negedge clk);
        send(1, 8'hD2, 1'b1);
      end
    join
    wait_quiet();
    chk("lock_cnts", {cnt1, cnt0}, {16'd4, 16'd3});
`endif

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
